// File: rtl/msg_uart_tx.sv
// Fixed-message UART transmitter: a button press sends MSG (most significant byte first) as 8N1/8N2 frames.
// Define MSG_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
`timescale 1ns/1ps
module msg_uart_tx #(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned MSG_LEN   = 11,
  parameter logic [MSG_LEN*8-1:0] MSG = 88'h69206C696B652046504741,
  parameter int unsigned STOP_BITS = 1,
`ifdef MSG_TX_PARITY_EN
  parameter int unsigned PARITY_ODD = 0,
`endif
  parameter int unsigned REPEAT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       out_tx,
  output logic       busy,
  output logic       done,
  output logic [4:0] byte_idx
);

  localparam int unsigned DIV      = CLK_HZ / BAUD;
  localparam int unsigned STOP_CYC = STOP_BITS * DIV;
  localparam int unsigned CW       = $clog2(STOP_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [4:0]    LAST_BYTE = 5'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MSG_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s0, r_s1, r_s2;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [4:0]    r_byte, w_byte_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_done, w_done_nxt;
  logic [7:0]    w_byte_sel;
  logic          w_start;
  logic          w_bit_end;
  logic          w_stop_end;

  assign w_start    = r_s1 & ~r_s2;
  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_stop_end = (r_cnt == STOP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) begin
          w_state_nxt = START;
          w_byte_nxt  = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef MSG_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef MSG_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
        end
      end
`endif
      STOP: begin
        if (w_stop_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = START;
          if (r_byte != LAST_BYTE) begin
            w_byte_nxt = r_byte + 5'd1;
          end else begin
            // Repeat mode samples the synchronised button level, not the edge, at message end.
            w_byte_nxt = '0;
            if (!((REPEAT != 0) && r_s1)) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_byte_sel = '0;
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      if (w_byte_nxt == 5'(i)) w_byte_sel = MSG[(MSG_LEN-1-i)*8 +: 8];
    end
  end

  // Line level is registered from the next-state decode so out_tx is glitch-free and aligned with busy.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:  w_tx_nxt = 1'b0;
      DATA:   w_tx_nxt = w_byte_sel[w_bit_nxt];
`ifdef MSG_TX_PARITY_EN
      PARITY: w_tx_nxt = (^w_byte_sel) ^ (PARITY_ODD != 0);
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_s0    <= btn;
      r_s1    <= r_s0;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign out_tx   = r_tx;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign byte_idx = r_byte;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Scoreboarded random-press bench for msg_uart_tx: three instances cover plain, repeat and two-stop-bit builds.
`timescale 1ns/1ps
module tb_msg_uart_tx;

  typedef struct {
    int start;
    int reps;
    int abort;
  } rec_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] btn;
  logic [2:0] tx_w, busy_w, done_w;
  logic [4:0] idx_w [3];
  int         cyc = 0;
  int         nchk = 0;
  int         npass = 0;
  logic [2:0] idle_bad = '0;
  rec_t       q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msg_uart_tx #(.CLK_HZ(1_600_000), .BAUD(100_000), .MSG_LEN(2), .MSG(16'h4869),
                .STOP_BITS(1),
`ifdef MSG_TX_PARITY_EN
                .PARITY_ODD(0),
`endif
                .REPEAT(0))
    u0 (.clk(clk), .rst(rst_n[0]), .btn(btn[0]), .out_tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .byte_idx(idx_w[0]));

  msg_uart_tx #(.CLK_HZ(1_900_000), .BAUD(100_000), .MSG_LEN(3), .MSG(24'hA53C01),
                .STOP_BITS(1),
`ifdef MSG_TX_PARITY_EN
                .PARITY_ODD(0),
`endif
                .REPEAT(1))
    u1 (.clk(clk), .rst(rst_n[1]), .btn(btn[1]), .out_tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .byte_idx(idx_w[1]));

  msg_uart_tx #(.CLK_HZ(1_700_000), .BAUD(100_000), .MSG_LEN(1), .MSG(8'hC3),
                .STOP_BITS(2),
`ifdef MSG_TX_PARITY_EN
                .PARITY_ODD(1),
`endif
                .REPEAT(0))
    u2 (.clk(clk), .rst(rst_n[2]), .btn(btn[2]), .out_tx(tx_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .byte_idx(idx_w[2]));

  // Reference configuration of each instance.
  function automatic int p_div(input int d);
    case (d) 0: return 16; 1: return 19; default: return 17; endcase
  endfunction
  function automatic int p_len(input int d);
    case (d) 0: return 2; 1: return 3; default: return 1; endcase
  endfunction
  function automatic int p_stop(input int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int p_rep(input int d);
    return (d == 1) ? 1 : 0;
  endfunction
  function automatic int p_podd(input int d);
    return (d == 2) ? 1 : 0;
  endfunction
  function automatic int p_par();
`ifdef MSG_TX_PARITY_EN
    return 1;
`else
    return 0;
`endif
  endfunction
  function automatic int p_frame(input int d);
    return 10 + p_par() + p_stop(d) - 1;
  endfunction
  function automatic logic [7:0] p_byte(input int d, input int b);
    logic [31:0] m;
    case (d) 0: m = 32'h4869; 1: m = 32'hA53C01; default: m = 32'hC3; endcase
    return m[8*(p_len(d)-1-b) +: 8];
  endfunction

  // Line level expected for bit j of a message stream (frames concatenated, message repeated).
  function automatic logic exp_tx(input int d, input int j);
    int F, p;
    logic [7:0] b;
    F = p_frame(d);
    p = j % F;
    b = p_byte(d, (j / F) % p_len(d));
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p_par() == 1 && p == 9) return (^b) ^ (p_podd(d) != 0);
    return 1'b1;
  endfunction

  function automatic logic [7:0] st(input int d);
    return {tx_w[d], busy_w[d], done_w[d], idx_w[d]};
  endfunction

  task automatic tally(input bit ok, input string what);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s", what);
  endtask

  task automatic chk(input string name, input int d, input int act, input int exp);
    tally(act == exp, $sformatf("%s dut%0d: got %0h want %0h", name, d, act, exp));
  endtask

  task automatic sb_push(input int d, input rec_t r);
    case (d) 0: q0.push_back(r); 1: q1.push_back(r); default: q2.push_back(r); endcase
  endtask

  task automatic sb_pop(input int d, output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '{0, 0, 0};
    case (d)
      0: if (q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin r = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int sb_size(input int d);
    case (d) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Stimulus: random presses; expected message timeline is queued at press time.
  task automatic drive(input int d);
    rec_t r;
    int   M, rel, endc;
    M = p_len(d) * p_frame(d) * p_div(d);
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(40, 4)) @(negedge clk);
      r.start = cyc + 3;
      r.reps  = (p_rep(d) != 0) ? int'($urandom_range(3, 1)) : 1;
      r.abort = 0;
      if (d == 0 && (it == 2 || $urandom_range(5, 0) == 0))
        r.abort = r.start + int'($urandom_range(M - 5, 20));
      sb_push(d, r);
      btn[d] = 1'b1;
      if (p_rep(d) != 0) rel = r.start + (r.reps - 1) * M + M / 2;
      else rel = cyc + int'($urandom_range(10, 1));
      wait_cyc(rel);
      btn[d] = 1'b0;
      if (r.abort != 0) begin
        wait_cyc(r.abort - 1);
        rst_n[d] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[d] = 1'b1;
        endc = r.abort;
      end else begin
        if (p_rep(d) == 0 && (it == 1 || $urandom_range(1, 0) == 1)) begin
          wait_cyc(r.start + M / 3);
          btn[d] = 1'b1;
          repeat (3) @(negedge clk);
          btn[d] = 1'b0;
        end
        endc = r.start + r.reps * M;
      end
      wait_cyc(endc + 2);
    end
  endtask

  // Monitor: a frame starting on the line pops the next expectation and walks it cycle by cycle.
  task automatic mon(input int d);
    rec_t       r;
    bit         ok, ab;
    int         F, L, dv, nbits, errs, eidx;
    logic [7:0] exp, bad;
    F  = p_frame(d);
    L  = p_len(d);
    dv = p_div(d);
    forever begin
      @(posedge clk); #1;
      if (rst_n[d] !== 1'b1 || (busy_w[d] !== 1'b1 && tx_w[d] !== 1'b0)) begin
        if (done_w[d] !== 1'b0 || idx_w[d] !== 5'd0) idle_bad[d] = 1'b1;
        continue;
      end
      chk("idle_quiet", d, int'(idle_bad[d]), 0);
      idle_bad[d] = 1'b0;
      sb_pop(d, r, ok);
      if (!ok) begin
        chk("unexpected_frame_at_cyc", d, cyc, -1);
        for (int k = 0; k < 5000 && (busy_w[d] === 1'b1 || tx_w[d] === 1'b0); k++) begin
          @(posedge clk); #1;
        end
        continue;
      end
      chk("start_cyc", d, cyc, r.start);
      nbits = r.reps * L * F;
      ab    = 1'b0;
      for (int j = 0; j < nbits && !ab; j++) begin
        errs = 0;
        bad  = '0;
        eidx = (j / F) % L;
        exp  = {exp_tx(d, j), 1'b1, 1'b0, 5'(eidx)};
        for (int c = 0; c < dv; c++) begin
          if (j != 0 || c != 0) begin @(posedge clk); #1; end
          if (r.abort != 0 && cyc == r.abort) begin
            chk("abort_state", d, int'(st(d)), 'h80);
            ab = 1'b1;
            break;
          end
          if (st(d) !== exp) begin
            if (errs == 0) bad = st(d);
            errs++;
          end
        end
        if (!ab)
          tally(errs == 0, $sformatf("bit%0d dut%0d: got %h want %h in %0d of %0d cycles",
                                     j, d, bad, exp, errs, dv));
      end
      if (!ab) begin
        @(posedge clk); #1;
        chk("done_edge", d, int'(st(d)), 'hA0);
        @(posedge clk); #1;
        chk("done_single", d, int'(st(d)), 'h80);
      end
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    btn   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_state", d, int'(st(d)), 'h80);
    @(negedge clk);
    rst_n = '1;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
    fork
      drive(0);
      drive(1);
      drive(2);
    join
    repeat (50) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("sb_drained", d, sb_size(d), 0);
      chk("final_idle_quiet", d, int'(idle_bad[d]), 0);
      chk("final_line", d, int'(st(d)), 'h80);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/msg_uart_tx.md
MSG_UART_TX -- requirements
Module: msg_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate; divider DIV = CLK_HZ/BAUD (integer, floor), DIV >= 16 required.
REQ-003 SHALL have parameter MSG_LEN, default 11, message length in bytes, legal range 1..32.
REQ-004 SHALL have parameter MSG, width MSG_LEN*8, default 88'h69206C696B652046504741, message content; byte MSG_LEN-1 (most significant) is sent first.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter REPEAT, default 0; 1 = resend message continuously while btn held high.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 btn  input  1  raw asynchronous start request (button level).
REQ-010 out_tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high from start bit of first byte until end of last stop bit.
REQ-012 done  output  1  single-cycle pulse when the message completes.
REQ-013 byte_idx  output  5  index of byte currently on the line, counting up from 0 (first byte sent).

Function
REQ-014 btn SHALL pass a 3-flop synchronizer (s0,s1,s2); start event = s1 & ~s2.
REQ-015 If btn is first sampled high at edge k while idle, out_tx SHALL go low (start bit) from edge k+2.
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on start event; START->DATA after DIV cycles; DATA->PARITY (macro on) or STOP after 8 bits; PARITY->STOP after DIV cycles; STOP->START (next byte) or IDLE after STOP_BITS*DIV cycles.
REQ-017 Every bit SHALL last exactly DIV clk cycles; baud counter clears at each state entry; no bit-period drift across bytes.
REQ-018 Data bits SHALL be sent LSB first; bytes back-to-back with no idle gap.
REQ-019 Start events while busy SHALL be ignored, not queued.
REQ-020 done SHALL pulse in the cycle busy falls; busy and done low otherwise.
REQ-021 REPEAT=1: if s1 is high at end of last stop bit, SHALL restart at byte 0 with no gap and no done pulse; done pulses only on final completion.
REQ-022 MSG_LEN=1 SHALL send one frame then return to IDLE; byte_idx wraps to 0 at message end.

Reset
REQ-023 While rst low: out_tx=1, busy=0, done=0, byte_idx=0, FSM=IDLE, synchronizer flops=0, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately (out_tx high asynchronously); after release a new start event is required.

Configuration
REQ-025 Macro MSG_TX_PARITY_EN defined: parameter PARITY_ODD (default 0) exists; one parity bit (even if 0, odd if 1, over 8 data bits) sent after data, frame = 11 (+1 if STOP_BITS=2) bits.
REQ-026 Macro undefined: no PARITY state, no parity logic, frame = 10 (+1 if STOP_BITS=2) bits.

Verification (CLK_HZ=25_000_000, BAUD=9600, DIV=2604)
REQ-027 MSG_LEN=2, MSG=16'h4869, btn pulse 10 cycles -> line: 0, 0,0,0,1,0,0,1,0, 1 then 0, 1,0,0,1,0,1,1,0, 1; each bit 2604 cycles; done pulse at 52080 cycles after start bit.
REQ-028 Second btn rise 5000 cycles into message -> ignored; total busy still 52080 cycles, exactly one done.
REQ-029 rst low at cycle 30000 of message -> out_tx=1, busy=0 same cycle; no done; next btn rise restarts at byte_idx=0.
REQ-030 MSG_TX_PARITY_EN, PARITY_ODD=0, byte 0x48 -> parity bit 0, frame 28644 cycles; PARITY_ODD=1 -> parity bit 1.
REQ-031 REPEAT=1, btn held for 3 messages -> continuous frames, byte_idx 0,1,0,1,0,1, one done after release at end of third message.
REQ-032 STOP_BITS=2, MSG_LEN=1 -> stop high for 5208 cycles, busy length 28644 cycles.
